wb_arbiter: RTL and testbench

WB_ARBITER -- requirements
Module: wb_arbiter

---
 rtl/wb_arbiter_pkg.sv | 16 +
 rtl/defines.v | 8 +
 rtl/wb_arb_pick.sv | 31 +++
 rtl/wb_arbiter.sv | 162 ++++++++++++++++
 tb/tb_wb_arbiter.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/wb_arbiter_pkg.sv
// Shared types and helpers for the Wishbone multi-master arbiter.
package wb_arbiter_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StOwn,
        StAbort,
        StDrain
    } arb_state_e;

    // Watchdog counter width; a disabled watchdog still keeps a 1-bit register.
    function automatic int unsigned cnt_width(input int unsigned timeout);
        return (timeout < 2) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/defines.v
// Arbitration policy selectors shared by the arbiter RTL and anything that instantiates it.
`ifndef WB_ARB_DEFINES_V
`define WB_ARB_DEFINES_V

`define ARB_MODE_FIXED 0
`define ARB_MODE_RR    1

`endif

// File: rtl/wb_arb_pick.sv
// Rotating-priority picker: first asserted request at or after start_i, wrapping modulo N.
module wb_arb_pick #(
    parameter int unsigned N    = 3,
    parameter int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]    req_i,
    input  logic [IdxW-1:0] start_i,
    output logic [N-1:0]    onehot_o,
    output logic [IdxW-1:0] idx_o,
    output logic            valid_o
);

    always_comb begin
        logic            found;
        logic [IdxW-1:0] j;
        found    = 1'b0;
        j        = '0;
        onehot_o = '0;
        idx_o    = '0;
        for (int unsigned k = 0; k < N; k++) begin
            j = IdxW'((32'(start_i) + k) % N);
            if (!found && req_i[j]) begin
                found       = 1'b1;
                onehot_o[j] = 1'b1;
                idx_o       = j;
            end
        end
        valid_o = found;
    end

endmodule

// File: rtl/wb_arbiter.sv
// Wishbone N-master to 1-slave arbiter with fixed or round-robin policy and a response watchdog.
`include "defines.v"

module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int unsigned NUM_MASTERS = 3,
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned MODE        = `ARB_MODE_FIXED,
    parameter int unsigned TIMEOUT     = 255
) (
    input  logic                                i_clk,
    input  logic                                i_reset_n,
    input  logic [NUM_MASTERS-1:0]              i_m_cyc,
    input  logic [NUM_MASTERS*(DATA_W/8)-1:0]   i_m_stb,
    input  logic [NUM_MASTERS-1:0]              i_m_we,
    input  logic [NUM_MASTERS*ADDR_W-1:0]       i_m_addr,
    input  logic [NUM_MASTERS*DATA_W-1:0]       i_m_dat,
    output logic [DATA_W-1:0]                   o_m_dat,
    output logic [NUM_MASTERS-1:0]              o_m_ack,
    output logic [NUM_MASTERS-1:0]              o_m_err,
    output logic [NUM_MASTERS-1:0]              o_grant,
    output logic                                o_wb_cyc,
    output logic                                o_wb_we,
    output logic [DATA_W/8-1:0]                 o_wb_stb,
    output logic [ADDR_W-1:0]                   o_wb_addr,
    output logic [DATA_W-1:0]                   o_wb_dat,
    input  logic [DATA_W-1:0]                   i_wb_dat,
    input  logic                                i_wb_ack,
    input  logic                                i_wb_err
);

    localparam int unsigned SEL_W = DATA_W / 8;
    localparam int unsigned IDX_W = $clog2(NUM_MASTERS);
    localparam int unsigned CNT_W = cnt_width(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_MASTERS - 1);

    arb_state_e             state_q, state_d;
    logic [IDX_W-1:0]       g_q, g_d;
    logic [IDX_W-1:0]       lo_q, lo_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [NUM_MASTERS-1:0] grant_q, grant_d;

    logic [IDX_W-1:0]       pick_start;
    logic [IDX_W-1:0]       pick_idx;
    logic [NUM_MASTERS-1:0] pick_onehot;
    logic                   pick_valid;

    always_comb begin
        pick_start = '0;
        if (MODE == `ARB_MODE_RR) begin
            pick_start = (lo_q == LAST_IDX) ? '0 : lo_q + 1'b1;
        end
    end

    wb_arb_pick #(
        .N    (NUM_MASTERS),
        .IdxW (IDX_W)
    ) u_pick (
        .req_i    (i_m_cyc),
        .start_i  (pick_start),
        .onehot_o (pick_onehot),
        .idx_o    (pick_idx),
        .valid_o  (pick_valid)
    );

    logic              sel_cyc;
    logic              sel_we;
    logic [SEL_W-1:0]  sel_stb;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_dat;
    logic              own;
    logic              resp;
    logic              timeout_hit;

    assign sel_cyc  = i_m_cyc[g_q];
    assign sel_we   = i_m_we[g_q];
    assign sel_stb  = i_m_stb[g_q*SEL_W +: SEL_W];
    assign sel_addr = i_m_addr[g_q*ADDR_W +: ADDR_W];
    assign sel_dat  = i_m_dat[g_q*DATA_W +: DATA_W];

    assign own  = (state_q == StOwn);
    assign resp = i_wb_ack | i_wb_err;
    // A response arriving in the final watchdog cycle still wins over the abort.
    assign timeout_hit = (TIMEOUT != 0) && (|sel_stb) && !resp && (cnt_q == CNT_LAST);

    always_comb begin
        state_d = state_q;
        g_d     = g_q;
        lo_d    = lo_q;
        cnt_d   = cnt_q;
        grant_d = grant_q;
        unique case (state_q)
            StIdle: begin
                if (pick_valid) begin
                    state_d = StOwn;
                    g_d     = pick_idx;
                    lo_d    = pick_idx;
                    grant_d = pick_onehot;
                    cnt_d   = '0;
                end
            end
            StOwn: begin
                if (!sel_cyc) begin
                    state_d = StIdle;
                    grant_d = '0;
                end else if (resp) begin
                    cnt_d = '0;
                end else if (timeout_hit) begin
                    state_d = StAbort;
                end else if (|sel_stb) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StAbort: begin
                state_d = StDrain;
                cnt_d   = '0;
            end
            StDrain: begin
                if (!sel_cyc) begin
                    state_d = StIdle;
                    grant_d = '0;
                end
            end
            default: begin
                state_d = StIdle;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= StIdle;
            g_q     <= '0;
            lo_q    <= LAST_IDX;
            cnt_q   <= '0;
            grant_q <= '0;
        end else begin
            state_q <= state_d;
            g_q     <= g_d;
            lo_q    <= lo_d;
            cnt_q   <= cnt_d;
            grant_q <= grant_d;
        end
    end

    always_comb begin
        o_grant   = grant_q;
        o_m_dat   = i_wb_dat;
        o_wb_cyc  = own & sel_cyc;
        o_wb_we   = own & sel_we;
        o_wb_stb  = own ? sel_stb  : '0;
        o_wb_addr = own ? sel_addr : '0;
        o_wb_dat  = own ? sel_dat  : '0;
        o_m_ack   = (own && i_wb_ack && !i_wb_err) ? grant_q : '0;
        o_m_err   = ((own && i_wb_err) || (state_q == StAbort)) ? grant_q : '0;
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench: a fixed-priority arbiter with a short watchdog and a round-robin one share stimulus.
module tb_wb_arbiter;

    localparam int unsigned N  = 3;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned SW = DW / 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0]    m_cyc, m_we;
    logic [N*SW-1:0] m_stb;
    logic [N*AW-1:0] m_addr;
    logic [N*DW-1:0] m_dat;
    logic [DW-1:0]   wb_dat_in;
    logic            wb_ack, wb_err;

    logic [DW-1:0] f_m_dat, r_m_dat;
    logic [N-1:0]  f_m_ack, f_m_err, f_grant, r_m_ack, r_m_err, r_grant;
    logic          f_wb_cyc, f_wb_we, r_wb_cyc, r_wb_we;
    logic [SW-1:0] f_wb_stb, r_wb_stb;
    logic [AW-1:0] f_wb_addr, r_wb_addr;
    logic [DW-1:0] f_wb_dat, r_wb_dat;

    wb_arbiter #(
        .NUM_MASTERS (N), .ADDR_W (AW), .DATA_W (DW), .MODE (0), .TIMEOUT (4)
    ) dut_f (
        .i_clk (clk), .i_reset_n (rst_n),
        .i_m_cyc (m_cyc), .i_m_stb (m_stb), .i_m_we (m_we), .i_m_addr (m_addr), .i_m_dat (m_dat),
        .o_m_dat (f_m_dat), .o_m_ack (f_m_ack), .o_m_err (f_m_err), .o_grant (f_grant),
        .o_wb_cyc (f_wb_cyc), .o_wb_we (f_wb_we), .o_wb_stb (f_wb_stb), .o_wb_addr (f_wb_addr),
        .o_wb_dat (f_wb_dat), .i_wb_dat (wb_dat_in), .i_wb_ack (wb_ack), .i_wb_err (wb_err)
    );

    wb_arbiter #(
        .NUM_MASTERS (N), .ADDR_W (AW), .DATA_W (DW), .MODE (1), .TIMEOUT (255)
    ) dut_r (
        .i_clk (clk), .i_reset_n (rst_n),
        .i_m_cyc (m_cyc), .i_m_stb (m_stb), .i_m_we (m_we), .i_m_addr (m_addr), .i_m_dat (m_dat),
        .o_m_dat (r_m_dat), .o_m_ack (r_m_ack), .o_m_err (r_m_err), .o_grant (r_grant),
        .o_wb_cyc (r_wb_cyc), .o_wb_we (r_wb_we), .o_wb_stb (r_wb_stb), .o_wb_addr (r_wb_addr),
        .o_wb_dat (r_wb_dat), .i_wb_dat (wb_dat_in), .i_wb_ack (wb_ack), .i_wb_err (wb_err)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic [N-1:0] cyc);
        m_cyc = cyc;
        for (int k = 0; k < int'(N); k++) begin
            m_stb[k*SW +: SW] = cyc[k] ? 4'hF : 4'h0;
        end
    endtask

    task automatic do_reset();
        rst_n  = 1'b0;
        wb_ack = 1'b0;
        wb_err = 1'b0;
        drive('0);
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    int          exp_seq [4] = '{0, 1, 2, 0};
    logic [N-1:0] exp_g;

    initial begin
        m_we      = 3'b010;
        wb_dat_in = 32'hCAFE_F00D;
        wb_ack    = 1'b0;
        wb_err    = 1'b0;
        for (int k = 0; k < int'(N); k++) begin
            m_addr[k*AW +: AW] = 32'h1000_0000 + 32'(k) * 32'h100;
            m_dat[k*DW +: DW]  = 32'hD000_0000 + 32'(k);
        end

        // Outputs held at zero while reset is asserted, even with requests pending.
        drive(3'b111);
        #3;
        check_eq("rst_grant_f", f_grant, 0);
        check_eq("rst_cyc_r", r_wb_cyc, 0);
        do_reset();
        #1;
        check_eq("post_rst_grant", f_grant, 0);
        check_eq("post_rst_stb", f_wb_stb, 0);

        // Slave response in IDLE ignored; read data always broadcast.
        wb_ack = 1'b1;
        wb_err = 1'b1;
        #1;
        check_eq("idle_ack", f_m_ack, 0);
        check_eq("idle_err", f_m_err, 0);
        check_eq("m_dat", f_m_dat, 32'hCAFE_F00D);
        wb_ack = 1'b0;
        wb_err = 1'b0;

        // Fixed priority: 3'b110 -> master 1.
        drive(3'b110);
        #1;
        check_eq("fix_idle_grant", f_grant, 0);
        step();
        check_eq("fix_grant", f_grant, 3'b010);
        check_eq("fix_addr", f_wb_addr, 32'h1000_0100);
        check_eq("fix_we", f_wb_we, 1);
        check_eq("fix_dat", f_wb_dat, 32'hD000_0001);
        wb_ack = 1'b1;
        #1;
        check_eq("fix_ack", f_m_ack, 3'b010);
        wb_ack = 1'b0;
        drive(3'b100);
        step();
        check_eq("fix_rel_gap", f_grant, 0);
        step();
        check_eq("fix_next_grant", f_grant, 3'b100);
        check_eq("fix_next_addr", f_wb_addr, 32'h1000_0200);

        // Round robin: all request, each releases after one ack.
        do_reset();
        drive(3'b111);
        step();
        for (int i = 0; i < 4; i++) begin
            exp_g = '0;
            exp_g[exp_seq[i]] = 1'b1;
            check_eq("rr_grant", r_grant, exp_g);
            wb_ack = 1'b1;
            #1;
            check_eq("rr_ack", r_m_ack, exp_g);
            wb_ack = 1'b0;
            drive(3'b111 & ~exp_g);
            step();
            check_eq("rr_gap", r_grant, 0);
            drive(3'b111);
            step();
        end

        // Burst lock: master 0 four beats, master 2 requests at beat 2.
        do_reset();
        drive(3'b001);
        step();
        for (int b = 1; b <= 4; b++) begin
            if (b == 2) drive(3'b101);
            wb_ack = 1'b1;
            #1;
            check_eq("burst_grant", r_grant, 3'b001);
            check_eq("burst_ack", r_m_ack, 3'b001);
            step();
        end
        wb_ack = 1'b0;
        drive(3'b100);
        #1;
        check_eq("burst_rel_grant", r_grant, 3'b001);
        step();
        check_eq("burst_gap", r_grant, 0);
        step();
        check_eq("burst_m2_grant", r_grant, 3'b100);
        check_eq("burst_m2_addr", r_wb_addr, 32'h1000_0200);

        // Fixed mode: lower-index request does not preempt current owner.
        do_reset();
        drive(3'b100);
        step();
        check_eq("nopre_grant0", f_grant, 3'b100);
        drive(3'b101);
        wb_ack = 1'b1;
        #1;
        check_eq("nopre_ack", f_m_ack, 3'b100);
        step();
        check_eq("nopre_grant1", f_grant, 3'b100);
        wb_ack = 1'b0;
        drive(3'b001);
        step();
        check_eq("nopre_gap", f_grant, 0);
        step();
        check_eq("nopre_m0", f_grant, 3'b001);

        // Watchdog (TIMEOUT=4), slave silent.
        do_reset();
        drive(3'b001);
        step();
        for (int c = 1; c <= 4; c++) begin
            check_eq("to_err_pre", f_m_err, 0);
            check_eq("to_cyc_pre", f_wb_cyc, 1);
            step();
        end
        check_eq("to_err", f_m_err, 3'b001);
        check_eq("to_cyc", f_wb_cyc, 0);
        check_eq("to_stb", f_wb_stb, 0);
        check_eq("to_grant", f_grant, 3'b001);
        step();
        check_eq("drain_err", f_m_err, 0);
        check_eq("drain_grant", f_grant, 3'b001);
        check_eq("drain_cyc", f_wb_cyc, 0);
        wb_ack = 1'b1;
        #1;
        check_eq("drain_ack_ignored", f_m_ack, 0);
        wb_ack = 1'b0;
        step();
        check_eq("drain_hold", f_grant, 3'b001);
        drive(3'b000);
        step();
        check_eq("drain_idle", f_grant, 0);

        // ack and err together: err wins.
        do_reset();
        drive(3'b010);
        step();
        wb_ack = 1'b1;
        wb_err = 1'b1;
        #1;
        check_eq("both_err_f", f_m_err, 3'b010);
        check_eq("both_ack_f", f_m_ack, 0);
        check_eq("both_err_r", r_m_err, 3'b010);
        wb_ack = 1'b0;
        wb_err = 1'b0;

        // Asynchronous reset mid-burst.
        do_reset();
        drive(3'b110);
        step();
        check_eq("ar_grant_pre", r_grant, 3'b010);
        step();
        #3;
        wb_ack = 1'b1;
        rst_n  = 1'b0;
        #1;
        check_eq("ar_cyc", r_wb_cyc, 0);
        check_eq("ar_grant", r_grant, 0);
        check_eq("ar_ack", r_m_ack, 0);
        wb_ack = 1'b0;
        drive(3'b111);
        #2;
        rst_n = 1'b1;
        #1;
        check_eq("ar_rel_grant", r_grant, 0);
        step();
        check_eq("ar_rr_first", r_grant, 3'b001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, expected finish before 200000");
        $fatal(1);
    end

endmodule
